// File: rtl/axi4lite_reg_responder.sv
// AXI4-Lite slave with three read/write registers and a read-only write-commit counter.
// Optional macro AXI4LITE_SLVERR_EN: writes to the counter register answer SLVERR instead of OKAY.
module axi4lite_reg_responder #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [DATA_WIDTH-1:0]     reg0_o,
  output logic [DATA_WIDTH-1:0]     reg1_o,
  output logic [DATA_WIDTH-1:0]     reg2_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

`ifdef AXI4LITE_SLVERR_EN
  localparam logic [1:0] CNT_WR_RESP = 2'b10;
`else
  localparam logic [1:0] CNT_WR_RESP = 2'b00;
`endif

  logic                  live_r;
  logic                  aw_full_r;
  logic [1:0]            aw_addr_r;
  logic                  w_full_r;
  logic [DATA_WIDTH-1:0] w_data_r;
  logic [STRB_WIDTH-1:0] w_strb_r;
  logic                  bvalid_r;
  logic [1:0]            bresp_r;
  logic                  rvalid_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [DATA_WIDTH-1:0] reg_r [0:3];

  logic                  aw_hs_s;
  logic                  w_hs_s;
  logic                  ar_hs_s;
  logic                  commit_s;
  logic                  commit_rw_s;
  logic [DATA_WIDTH-1:0] merged_s;

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (strb[i]) begin
        res[i*8 +: 8] = new_val[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_val[i*8 +: 8];
      end
    end
    return res;
  endfunction

  // Readies depend only on registered state, so they are glitch-free and low in reset.
  assign s_axi_awready = live_r & ~aw_full_r & ~bvalid_r;
  assign s_axi_wready  = live_r & ~w_full_r & ~bvalid_r;
  assign s_axi_arready = live_r & ~rvalid_r;

  assign aw_hs_s     = s_axi_awvalid & s_axi_awready;
  assign w_hs_s      = s_axi_wvalid & s_axi_wready;
  assign ar_hs_s     = s_axi_arvalid & s_axi_arready;
  assign commit_s    = aw_full_r & w_full_r & ~bvalid_r;
  assign commit_rw_s = commit_s & (aw_addr_r != 2'd3);

  // Byte-lane merge of the held write data into the targeted register.
  always_comb begin
    merged_s = merge_lanes(reg_r[aw_addr_r], w_data_r, w_strb_r);
  end

  assign s_axi_bvalid = bvalid_r;
  assign s_axi_bresp  = bresp_r;
  assign s_axi_rvalid = rvalid_r;
  assign s_axi_rdata  = rdata_r;
  assign s_axi_rresp  = 2'b00;
  assign reg0_o       = reg_r[0];
  assign reg1_o       = reg_r[1];
  assign reg2_o       = reg_r[2];

  // Write path: AW/W holders, commit and B response.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      live_r    <= 1'b0;
      aw_full_r <= 1'b0;
      aw_addr_r <= 2'b00;
      w_full_r  <= 1'b0;
      w_data_r  <= '0;
      w_strb_r  <= '0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
    end else begin
      live_r <= 1'b1;
      if (commit_s) begin
        aw_full_r <= 1'b0;
        w_full_r  <= 1'b0;
        bvalid_r  <= 1'b1;
        bresp_r   <= (aw_addr_r == 2'd3) ? CNT_WR_RESP : 2'b00;
      end else begin
        if (aw_hs_s) begin
          aw_full_r <= 1'b1;
          aw_addr_r <= s_axi_awaddr[1:0];
        end
        if (w_hs_s) begin
          w_full_r <= 1'b1;
          w_data_r <= s_axi_wdata;
          w_strb_r <= s_axi_wstrb;
        end
        if (bvalid_r && s_axi_bready) begin
          bvalid_r <= 1'b0;
        end
      end
    end
  end

  // Register file; register 3 counts commits to registers 0-2.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < 4; i++) begin
        reg_r[i] <= '0;
      end
    end else if (commit_rw_s) begin
      reg_r[aw_addr_r] <= merged_s;
      reg_r[3]         <= reg_r[3] + DATA_WIDTH'(1);
    end
  end

  // Read path: the register is sampled on the AR handshake edge, so a coincident commit is not seen.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rdata_r  <= reg_r[s_axi_araddr[1:0]];
    end else if (rvalid_r && s_axi_rready) begin
      rvalid_r <= 1'b0;
    end
  end

endmodule
